// File: rtl/div_rs_pkg.sv
`default_nettype none
// ============================================================================
// Module   : div_rs_pkg
// Purpose  : Shared types, encodings and helpers for the divide reservation
//            station.
// Revision : 1.0 - initial release
// ============================================================================
package div_rs_pkg;

    // Machine-wide configuration: ROB depth and the widest physical tag.
    localparam int c_rob_len   = 16;
    localparam int c_rob_idx_w = $clog2(c_rob_len);
    localparam int c_tag_max_w = 8;

    typedef enum logic [2:0] {
        F3_DIV  = 3'b100,
        F3_DIVU = 3'b101,
        F3_REM  = 3'b110,
        F3_REMU = 3'b111
    } div_funct3_e;

    typedef struct packed {
        logic [c_tag_max_w-1:0] tag;
        logic                   rdy;
        logic [31:0]            data;
    } src_t;

    typedef struct packed {
        logic                   valid;
        logic [2:0]             funct3;
        logic [c_rob_idx_w-1:0] rob_idx;
        logic [c_tag_max_w-1:0] rd;
        src_t                   rs1;
        src_t                   rs2;
    } rs_entry_t;

    // A waiting source captures a matching CDB broadcast; shared by the
    // dispatch bypass and the per-entry wakeup so both follow one rule.
    function automatic src_t src_wakeup(input src_t                   s,
                                        input logic                   cdb_valid,
                                        input logic [c_tag_max_w-1:0] cdb_tag,
                                        input logic [31:0]            cdb_data);
        src_t r;
        r = s;
        if (!s.rdy && cdb_valid && (s.tag == cdb_tag)) begin
            r.rdy  = 1'b1;
            r.data = cdb_data;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/div_rs_if.sv
`default_nettype none
// ============================================================================
// Module   : div_rs_if
// Purpose  : Dispatch, wakeup, flush and issue signals of the divide station.
// Revision : 1.0 - initial release
// ============================================================================
interface div_rs_if
    import div_rs_pkg::*;
#(
    parameter int ENTRIES = 4,
    parameter int PREG_W  = 7
);
    logic                     disp_valid;
    logic                     disp_ready;
    logic [2:0]               disp_funct3;
    logic [c_rob_idx_w-1:0]   disp_rob_idx;
    logic [PREG_W-1:0]        disp_rd;
    logic [PREG_W-1:0]        disp_rs1_tag;
    logic [PREG_W-1:0]        disp_rs2_tag;
    logic                     disp_rs1_rdy;
    logic                     disp_rs2_rdy;
    logic [31:0]              disp_rs1_data;
    logic [31:0]              disp_rs2_data;

    logic                     cdb_valid;
    logic [PREG_W-1:0]        cdb_tag;
    logic [31:0]              cdb_data;

    logic                     mispredict;
    logic [c_rob_len-1:0]     flush_mask;

    logic                     div_i_valid;
    logic                     div_i_ready;
    logic [2:0]               div_funct3;
    logic [31:0]              div_rs1_data;
    logic [31:0]              div_rs2_data;
    logic [c_rob_idx_w-1:0]   div_rob_idx;
    logic [PREG_W-1:0]        div_rd;

    logic [$clog2(ENTRIES):0] occupancy;

    modport master (
        output disp_valid, disp_funct3, disp_rob_idx, disp_rd,
               disp_rs1_tag, disp_rs2_tag, disp_rs1_rdy, disp_rs2_rdy,
               disp_rs1_data, disp_rs2_data,
               cdb_valid, cdb_tag, cdb_data, mispredict, flush_mask,
               div_i_ready,
        input  disp_ready, div_i_valid, div_funct3, div_rs1_data,
               div_rs2_data, div_rob_idx, div_rd, occupancy
    );

    modport slave (
        input  disp_valid, disp_funct3, disp_rob_idx, disp_rd,
               disp_rs1_tag, disp_rs2_tag, disp_rs1_rdy, disp_rs2_rdy,
               disp_rs1_data, disp_rs2_data,
               cdb_valid, cdb_tag, cdb_data, mispredict, flush_mask,
               div_i_ready,
        output disp_ready, div_i_valid, div_funct3, div_rs1_data,
               div_rs2_data, div_rob_idx, div_rd, occupancy
    );

endinterface
`default_nettype wire

// File: rtl/div_rs_age_matrix_sel.sv
`default_nettype none
// ============================================================================
// Module   : age_matrix_sel
// Purpose  : Age matrix tracking dispatch order; grants the oldest requester.
// Revision : 1.0 - initial release
// ============================================================================
module age_matrix_sel #(
    parameter int ENTRIES = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [ENTRIES-1:0] alloc,
    input  logic [ENTRIES-1:0] req,
    output logic [ENTRIES-1:0] grant
);

    // r_older[i][j] set means entry i was dispatched before entry j.
    logic [ENTRIES-1:0] r_older [ENTRIES];
    logic [ENTRIES-1:0] w_blocked;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_older[i] <= '0;
            end
        end else begin
            for (int i = 0; i < ENTRIES; i++) begin
                for (int j = 0; j < ENTRIES; j++) begin
                    if (alloc[i]) begin
                        r_older[i][j] <= 1'b0;
                    end else if (alloc[j]) begin
                        r_older[i][j] <= 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        w_blocked = '0;
        grant     = '0;
        for (int j = 0; j < ENTRIES; j++) begin
            for (int i = 0; i < ENTRIES; i++) begin
                if (req[i] && r_older[i][j]) begin
                    w_blocked[j] = 1'b1;
                end
            end
            grant[j] = req[j] & ~w_blocked[j];
        end
    end

endmodule
`default_nettype wire

// File: rtl/div_rs.sv
`default_nettype none
// ============================================================================
// Module   : div_rs
// Purpose  : Divide-unit reservation station: dispatch, CDB wakeup, oldest-
//            first issue and mispredict flush.
// Revision : 1.0 - initial release
// ============================================================================
module div_rs
    import div_rs_pkg::*;
#(
    parameter int ENTRIES = 4,
    parameter int PREG_W  = 7
) (
    input  logic    clk,
    input  logic    rst,
    div_rs_if.slave bus
);

    localparam int c_idx_w = $clog2(ENTRIES);
    localparam int c_occ_w = $clog2(ENTRIES) + 1;

    rs_entry_t              r_ent [ENTRIES];
    rs_entry_t              w_new;
    rs_entry_t              w_sel;
    src_t                   w_src1;
    src_t                   w_src2;
    logic [ENTRIES-1:0]     w_valid;
    logic [ENTRIES-1:0]     w_elig;
    logic [ENTRIES-1:0]     w_kill;
    logic [ENTRIES-1:0]     w_req;
    logic [ENTRIES-1:0]     w_grant;
    logic [ENTRIES-1:0]     w_alloc;
    logic [c_idx_w-1:0]     w_alloc_idx;
    logic [c_occ_w-1:0]     w_occ;
    logic [c_tag_max_w-1:0] w_cdb_tag;
    logic                   w_disp_fire;
    logic                   w_issue_fire;

    assign w_cdb_tag = c_tag_max_w'(bus.cdb_tag);

    always_comb begin
        w_valid     = '0;
        w_elig      = '0;
        w_kill      = '0;
        w_occ       = '0;
        w_alloc_idx = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            w_valid[i] = r_ent[i].valid;
            w_elig[i]  = r_ent[i].valid & r_ent[i].rs1.rdy & r_ent[i].rs2.rdy;
            w_kill[i]  = bus.mispredict & r_ent[i].valid
                       & bus.flush_mask[r_ent[i].rob_idx];
            w_occ      = w_occ + c_occ_w'(r_ent[i].valid);
        end
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (!r_ent[i].valid) begin
                w_alloc_idx = c_idx_w'(i);
            end
        end
    end

    // Only registered occupancy gates dispatch; a slot freed by this cycle's
    // issue becomes usable next cycle.
    assign bus.disp_ready = ~(&w_valid) & ~bus.mispredict;
    assign w_disp_fire    = bus.disp_valid & bus.disp_ready;
    assign w_alloc        = w_disp_fire ? (ENTRIES'(1) << w_alloc_idx) : '0;
    assign w_req          = w_elig & ~w_kill;

    age_matrix_sel #(
        .ENTRIES (ENTRIES)
    ) u_age_sel (
        .clk   (clk),
        .rst   (rst),
        .alloc (w_alloc),
        .req   (w_req),
        .grant (w_grant)
    );

    always_comb begin
        w_sel = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (w_grant[i]) begin
                w_sel = r_ent[i];
            end
        end
    end

    assign bus.div_i_valid  = |w_req;
    assign w_issue_fire     = bus.div_i_valid & bus.div_i_ready;
    assign bus.div_funct3   = w_sel.funct3;
    assign bus.div_rs1_data = w_sel.rs1.data;
    assign bus.div_rs2_data = w_sel.rs2.data;
    assign bus.div_rob_idx  = w_sel.rob_idx;
    assign bus.div_rd       = PREG_W'(w_sel.rd);
    assign bus.occupancy    = w_occ;

    always_comb begin
        w_src1      = '0;
        w_src2      = '0;
        w_src1.tag  = c_tag_max_w'(bus.disp_rs1_tag);
        w_src1.rdy  = bus.disp_rs1_rdy;
        w_src1.data = bus.disp_rs1_data;
        w_src2.tag  = c_tag_max_w'(bus.disp_rs2_tag);
        w_src2.rdy  = bus.disp_rs2_rdy;
        w_src2.data = bus.disp_rs2_data;

        w_new         = '0;
        w_new.valid   = 1'b1;
        w_new.funct3  = bus.disp_funct3;
        w_new.rob_idx = bus.disp_rob_idx;
        w_new.rd      = c_tag_max_w'(bus.disp_rd);
        w_new.rs1     = src_wakeup(w_src1, bus.cdb_valid, w_cdb_tag, bus.cdb_data);
        w_new.rs2     = src_wakeup(w_src2, bus.cdb_valid, w_cdb_tag, bus.cdb_data);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_ent[i].valid <= 1'b0;
            end
        end else begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_ent[i].rs1 <= src_wakeup(r_ent[i].rs1, bus.cdb_valid, w_cdb_tag, bus.cdb_data);
                r_ent[i].rs2 <= src_wakeup(r_ent[i].rs2, bus.cdb_valid, w_cdb_tag, bus.cdb_data);
                if (w_kill[i] || (w_issue_fire && w_grant[i])) begin
                    r_ent[i].valid <= 1'b0;
                end
                // Allocation only targets a free slot, so it never collides
                // with an issue or flush of the same entry.
                if (w_alloc[i]) begin
                    r_ent[i] <= w_new;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_div_rs.sv
`default_nettype none
// ============================================================================
// Module   : tb_div_rs
// Purpose  : Self-checking bench for div_rs against an age-ordered queue model.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_div_rs;
    import div_rs_pkg::*;

    localparam int ENTRIES = 4;
    localparam int PREG_W  = 7;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    div_rs_if #(.ENTRIES(ENTRIES), .PREG_W(PREG_W)) bus ();

    div_rs #(
        .ENTRIES (ENTRIES),
        .PREG_W  (PREG_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Model: live ops in dispatch order, oldest first.
    typedef struct {
        logic [2:0]  f3;
        int          rob;
        int          rd;
        int          t1;
        int          t2;
        bit          r1;
        bit          r2;
        logic [31:0] d1;
        logic [31:0] d2;
    } m_ent_t;

    m_ent_t q[$];
    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic m_ent_t wake(input m_ent_t e);
        m_ent_t r;
        r = e;
        if (bus.cdb_valid && !r.r1 && r.t1 == int'(bus.cdb_tag)) begin
            r.r1 = 1'b1;
            r.d1 = bus.cdb_data;
        end
        if (bus.cdb_valid && !r.r2 && r.t2 == int'(bus.cdb_tag)) begin
            r.r2 = 1'b1;
            r.d2 = bus.cdb_data;
        end
        return r;
    endfunction

    // Compare all outputs against the model, then advance the model and clock.
    task automatic step();
        bit     exp_ready;
        int     sel;
        m_ent_t nq[$];
        m_ent_t e;
        #1;
        exp_ready = (q.size() < ENTRIES) && !bus.mispredict;
        sel = -1;
        foreach (q[i]) begin
            if (sel < 0 && q[i].r1 && q[i].r2 && !(bus.mispredict && bus.flush_mask[q[i].rob]))
                sel = i;
        end
        if (!rst) begin
            check("disp_ready", 32'(bus.disp_ready), 32'(exp_ready));
            check("occupancy", 32'(bus.occupancy), q.size());
            check("div_i_valid", 32'(bus.div_i_valid), 32'(sel >= 0));
            if (sel >= 0) begin
                check("div_funct3", 32'(bus.div_funct3), 32'(q[sel].f3));
                check("div_rs1_data", bus.div_rs1_data, q[sel].d1);
                check("div_rs2_data", bus.div_rs2_data, q[sel].d2);
                check("div_rob_idx", 32'(bus.div_rob_idx), q[sel].rob);
                check("div_rd", 32'(bus.div_rd), q[sel].rd);
            end
        end
        if (rst) begin
            q.delete();
        end else begin
            foreach (q[i]) begin
                if (bus.mispredict && bus.flush_mask[q[i].rob]) continue;
                if (i == sel && bus.div_i_ready) continue;
                nq.push_back(wake(q[i]));
            end
            if (bus.disp_valid && exp_ready) begin
                e.f3 = bus.disp_funct3;     e.rob = int'(bus.disp_rob_idx);
                e.rd = int'(bus.disp_rd);
                e.t1 = int'(bus.disp_rs1_tag); e.r1 = bus.disp_rs1_rdy; e.d1 = bus.disp_rs1_data;
                e.t2 = int'(bus.disp_rs2_tag); e.r2 = bus.disp_rs2_rdy; e.d2 = bus.disp_rs2_data;
                nq.push_back(wake(e));
            end
            q = nq;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        bus.disp_valid    = 1'b0;
        bus.disp_funct3   = 3'b100;
        bus.disp_rob_idx  = '0;
        bus.disp_rd       = '0;
        bus.disp_rs1_tag  = '0;
        bus.disp_rs2_tag  = '0;
        bus.disp_rs1_rdy  = 1'b0;
        bus.disp_rs2_rdy  = 1'b0;
        bus.disp_rs1_data = '0;
        bus.disp_rs2_data = '0;
        bus.cdb_valid     = 1'b0;
        bus.cdb_tag       = '0;
        bus.cdb_data      = '0;
        bus.mispredict    = 1'b0;
        bus.flush_mask    = '0;
    endtask

    task automatic set_disp(input bit v, input logic [2:0] f3, input int rob, input int rd,
                            input int t1, input bit r1, input logic [31:0] d1,
                            input int t2, input bit r2, input logic [31:0] d2);
        bus.disp_valid    = v;
        bus.disp_funct3   = f3;
        bus.disp_rob_idx  = c_rob_idx_w'(rob);
        bus.disp_rd       = PREG_W'(rd);
        bus.disp_rs1_tag  = PREG_W'(t1);
        bus.disp_rs1_rdy  = r1;
        bus.disp_rs1_data = d1;
        bus.disp_rs2_tag  = PREG_W'(t2);
        bus.disp_rs2_rdy  = r2;
        bus.disp_rs2_data = d2;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        bus.div_i_ready = 1'b0;
        @(negedge clk);
        step();
        step();
        rst = 1'b0;
        #1;
        check("rst_occupancy", 32'(bus.occupancy), 0);
        check("rst_div_i_valid", 32'(bus.div_i_valid), 0);
        check("rst_disp_ready", 32'(bus.disp_ready), 1);
        step();

        // Single ready op issues one cycle after dispatch.
        bus.div_i_ready = 1'b1;
        set_disp(1, F3_DIV, 1, 10, 1, 1, 100, 2, 1, 7);
        step();
        idle();
        #1;
        check("lat_valid", 32'(bus.div_i_valid), 1);
        check("lat_rs1", bus.div_rs1_data, 100);
        check("lat_rs2", bus.div_rs2_data, 7);
        check("lat_occ1", 32'(bus.occupancy), 1);
        step();
        #1;
        check("lat_occ0", 32'(bus.occupancy), 0);
        check("lat_idle", 32'(bus.div_i_valid), 0);
        step();

        // Waiting op A is overtaken by ready op B, then woken by the CDB.
        set_disp(1, F3_DIVU, 2, 11, 20, 1, 50, 5, 0, 0);
        step();
        set_disp(1, F3_REM, 3, 12, 21, 1, 40, 22, 1, 4);
        step();
        idle();
        bus.cdb_valid = 1'b1; bus.cdb_tag = 7'd5; bus.cdb_data = 32'd3;
        #1;
        check("wake_first_rob", 32'(bus.div_rob_idx), 3);
        step();
        idle();
        #1;
        check("wake_second_rob", 32'(bus.div_rob_idx), 2);
        check("wake_second_rs2", bus.div_rs2_data, 3);
        step();
        step();

        // Full station: a slot freed by issue is visible one cycle later.
        bus.div_i_ready = 1'b0;
        for (int k = 0; k < ENTRIES; k++) begin
            set_disp(1, F3_DIV, k, k, 30, 1, 32'(k + 1), 31, 1, 1);
            step();
        end
        idle();
        #1;
        check("full_occ", 32'(bus.occupancy), 4);
        bus.div_i_ready = 1'b1;
        #1;
        check("full_ready_t", 32'(bus.disp_ready), 0);
        step();
        bus.div_i_ready = 1'b0;
        #1;
        check("full_ready_t1", 32'(bus.disp_ready), 1);
        step();
        bus.div_i_ready = 1'b1;
        repeat (3) step();
        step();

        // Backpressure: presented op stays stable, older one goes first.
        bus.div_i_ready = 1'b0;
        set_disp(1, F3_DIV, 4, 40, 1, 1, 200, 2, 1, 9);
        step();
        set_disp(1, F3_REMU, 5, 41, 1, 1, 300, 2, 1, 11);
        step();
        idle();
        for (int k = 0; k < 3; k++) begin
            #1;
            check("hold_rob", 32'(bus.div_rob_idx), 4);
            check("hold_rs1", bus.div_rs1_data, 200);
            step();
        end
        bus.div_i_ready = 1'b1;
        #1;
        check("hold_first", 32'(bus.div_rob_idx), 4);
        step();
        #1;
        check("hold_second", 32'(bus.div_rob_idx), 5);
        step();
        step();

        // Flush of rob 3 and 4 leaves rob 2; flushed older ops never present.
        bus.div_i_ready = 1'b0;
        set_disp(1, F3_DIV, 3, 50, 1, 1, 13, 2, 1, 1);
        step();
        set_disp(1, F3_DIV, 4, 51, 1, 1, 14, 2, 1, 1);
        step();
        set_disp(1, F3_DIV, 2, 52, 1, 1, 12, 2, 1, 1);
        step();
        idle();
        bus.mispredict = 1'b1;
        bus.flush_mask = 16'h0018;
        #1;
        check("flush_sel_rob", 32'(bus.div_rob_idx), 2);
        step();
        idle();
        #1;
        check("flush_occ", 32'(bus.occupancy), 1);
        check("flush_left_rob", 32'(bus.div_rob_idx), 2);
        bus.div_i_ready = 1'b1;
        step();
        step();

        // Reset mid-operation overrides dispatch, wakeup and issue.
        bus.div_i_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            set_disp(1, F3_DIVU, k + 6, 60 + k, 1, 1, 32'(k), 2, 1, 5);
            step();
        end
        rst = 1'b1;
        set_disp(1, F3_DIV, 9, 70, 1, 1, 1, 2, 1, 1);
        bus.cdb_valid = 1'b1;
        bus.div_i_ready = 1'b1;
        step();
        rst = 1'b0;
        idle();
        #1;
        check("rst_mid_occ", 32'(bus.occupancy), 0);
        check("rst_mid_valid", 32'(bus.div_i_valid), 0);
        step();

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            idle();
            rst = ($urandom_range(0, 299) == 0);
            set_disp($urandom_range(0, 9) < 6, 3'(4 + $urandom_range(0, 3)),
                     int'($urandom_range(0, 15)), int'($urandom_range(0, 127)),
                     int'($urandom_range(0, 15)), bit'($urandom_range(0, 1)), $urandom,
                     int'($urandom_range(0, 15)), bit'($urandom_range(0, 1)), $urandom);
            bus.cdb_valid   = ($urandom_range(0, 1) == 1);
            bus.cdb_tag     = PREG_W'($urandom_range(0, 15));
            bus.cdb_data    = $urandom;
            bus.mispredict  = ($urandom_range(0, 14) == 0);
            bus.flush_mask  = 16'($urandom);
            bus.div_i_ready = ($urandom_range(0, 9) < 6);
            step();
        end
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/div_rs.md
DIV_RS -- requirements
Module: div_rs

Interface
REQ-001 Parameter ENTRIES, default 4, number of reservation-station entries (power of two, 2..8).
REQ-002 Parameter PREG_W, default 7, physical-register tag width.
REQ-003 clk  input  1  clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 disp_valid  input  1  dispatch request for one divide op.
REQ-006 disp_ready  output  1  station can accept the dispatch this cycle.
REQ-007 disp_funct3  input  3  100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-008 disp_rob_idx  input  $clog2(ROB_LEN)  ROB index of the op.
REQ-009 disp_rd  input  PREG_W  destination tag.
REQ-010 disp_rs1_tag / disp_rs2_tag  input  PREG_W each  source tags.
REQ-011 disp_rs1_rdy / disp_rs2_rdy  input  1 each  source value is already valid.
REQ-012 disp_rs1_data / disp_rs2_data  input  32 each  source values, meaningful when the matching rdy is 1.
REQ-013 cdb_valid, cdb_tag[PREG_W], cdb_data[32]  input  result broadcast used for wakeup.
REQ-014 mispredict  input  1; flush_mask  input  ROB_LEN  per-ROB-entry kill vector.
REQ-015 div_i_valid  output  1; div_i_ready  input  1  issue handshake to the divider.
REQ-016 div_funct3[3], div_rs1_data[32], div_rs2_data[32], div_rob_idx, div_rd[PREG_W]  outputs  issued op fields.
REQ-017 occupancy  output  $clog2(ENTRIES)+1  number of valid entries.

Function
REQ-018 An entry holds: valid, funct3, rob_idx, rd, and per source tag, rdy and data.
REQ-019 disp_ready SHALL be 1 iff at least one entry is invalid at the start of the cycle and mispredict is 0; slots freed by same-cycle issue SHALL NOT count.
REQ-020 A dispatch is accepted when disp_valid & disp_ready; it is written into the lowest-index free entry.
REQ-021 Dispatch bypass: a source with rdy=0 whose tag equals cdb_tag while cdb_valid=1 in the same cycle SHALL be stored with rdy=1 and data=cdb_data.
REQ-022 Wakeup: each valid entry source with rdy=0 and tag==cdb_tag while cdb_valid=1 SHALL capture cdb_data and set rdy=1 on the next edge.
REQ-023 An entry is eligible when valid and both sources are rdy in registered state; minimum dispatch-to-issue latency is 1 cycle.
REQ-024 Select: oldest eligible entry by dispatch order, tracked with an ENTRIES x ENTRIES age matrix.
REQ-025 div_i_valid SHALL be 1 iff an eligible entry exists and that entry is not being flushed this cycle; the div_* fields come combinationally from the selected entry.
REQ-026 Issue occurs on div_i_valid & div_i_ready; the selected entry is freed on that edge.
REQ-027 While div_i_ready=0, the same oldest eligible entry SHALL stay presented with stable fields, unless an older entry becomes eligible.
REQ-028 Flush: when mispredict=1, every valid entry with flush_mask[rob_idx]=1 SHALL be cleared on that edge, and flushed entries SHALL NOT be issued that cycle.
REQ-029 Surviving entries keep their age order across a flush.
REQ-030 Simultaneous issue and dispatch in one cycle are both honored.
REQ-031 occupancy reflects registered state: dispatches +1, issues -1, flushes -k, all applied on the next edge.

Reset
REQ-032 On rst, all entry valid bits and the age matrix SHALL clear. After reset: occupancy=0, div_i_valid=0, disp_ready=1 once rst deasserts.
REQ-033 rst SHALL override any concurrent dispatch, wakeup or issue.

Structure
REQ-034 The entry struct type and the funct3 encodings SHALL live in the shared CPU package; ROB_LEN comes from config.svh.
REQ-035 Oldest-eligible selection SHALL be a sub-module, age_matrix_sel (request vector in, one-hot grant out).

Verification
REQ-036 Dispatch DIV 100/7 with both sources rdy, div_i_ready=1 -> div_i_valid=1 exactly one cycle later with rs1=100, rs2=7; occupancy goes 1 then 0.
REQ-037 Dispatch A (rs2 tag 5 not rdy), then B fully ready; then cdb tag 5 data 3 -> B issues first; A issues the cycle after wakeup with rs2=3.
REQ-038 Fill 4 entries -> disp_ready=0; issue one in cycle t -> disp_ready=1 in t+1, not in t.
REQ-039 Hold div_i_ready=0 for 3 cycles with 2 eligible entries -> fields stable, no entry lost; the older entry issues first when ready rises.
REQ-040 Entries with rob_idx 2,3,4 and mispredict with mask bits 3,4 set -> only rob 2 remains, occupancy=1, no issue of rob 3 or 4.
REQ-041 Assert rst mid-operation with 3 entries valid -> occupancy=0 and div_i_valid=0 on the next cycle.
